// File: rtl/deadline_timer64.sv
// Deadline/alarm timer driven by a free-running timestamp stream.
// Supports one-shot and drift-free periodic firing using modular compare.
module deadline_timer64 #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_counter,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_duration,
  input  logic                  i_periodic,
  input  logic                  i_cancel,
  output logic                  o_busy,
  output logic                  o_fire,
  output logic                  o_fire_late,
  output logic [DATA_WIDTH-1:0] o_fire_stamp
);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [DATA_WIDTH-1:0] r_deadline;
  logic [DATA_WIDTH-1:0] r_period;
  logic                  r_periodic;
  logic                  r_fire;
  logic                  r_fireLate;
  logic [DATA_WIDTH-1:0] r_fireStamp;

  logic [DATA_WIDTH-1:0] w_diff;
  logic [DATA_WIDTH-1:0] w_dur;
  logic                  w_match;

  // Sign bit of the modular difference tells "at or past" within half range.
  assign w_diff  = i_counter - r_deadline;
  assign w_match = (r_state == ARMED) && !w_diff[DATA_WIDTH-1];
  assign w_dur   = (i_duration == '0) ? {{(DATA_WIDTH-1){1'b0}}, 1'b1} : i_duration;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (i_cancel) begin
      w_nextState = IDLE;
    end else if (i_start) begin
      w_nextState = ARMED;
    end else if (w_match && !r_periodic) begin
      w_nextState = IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_deadline  <= '0;
      r_period    <= '0;
      r_periodic  <= 1'b0;
      r_fire      <= 1'b0;
      r_fireLate  <= 1'b0;
      r_fireStamp <= '0;
    end else begin
      r_fire <= 1'b0;
      if (i_cancel) begin
        r_periodic <= r_periodic;
      end else if (i_start) begin
        r_period   <= w_dur;
        r_deadline <= i_counter + w_dur;
        r_periodic <= i_periodic;
      end else if (w_match) begin
        r_fire      <= 1'b1;
        r_fireStamp <= i_counter;
        r_fireLate  <= (w_diff != '0);
        // Advance from the old deadline, not the counter, so periods never drift.
        if (r_periodic) begin
          r_deadline <= r_deadline + r_period;
        end
      end
    end
  end

  assign o_busy       = (r_state == ARMED);
  assign o_fire       = r_fire;
  assign o_fire_late  = r_fireLate;
  assign o_fire_stamp = r_fireStamp;

endmodule

// File: tb/tb_deadline_timer64.sv
// Directed self-checking bench for deadline_timer64.
module tb_deadline_timer64;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] counter;
  logic        start;
  logic [63:0] duration;
  logic        periodic;
  logic        cancel;
  logic        busy;
  logic        fire;
  logic        fireLate;
  logic [63:0] fireStamp;

  int checks = 0;
  int failures = 0;

  deadline_timer64 #(.DATA_WIDTH(64)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_counter    (counter),
    .i_start      (start),
    .i_duration   (duration),
    .i_periodic   (periodic),
    .i_cancel     (cancel),
    .o_busy       (busy),
    .o_fire       (fire),
    .o_fire_late  (fireLate),
    .o_fire_stamp (fireStamp)
  );

  always #5 clk = ~clk;

  // One clock: outputs are sampled 1ns after the edge, pulses cleared, counter advanced.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    start   = 1'b0;
    cancel  = 1'b0;
    counter = counter + 64'd1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic armTimer(input logic [63:0] cnt, input logic [63:0] dur, input logic per);
    counter  = cnt;
    duration = dur;
    periodic = per;
    start    = 1'b1;
  endtask

  initial begin
    reset = 1'b1; counter = '0; start = 1'b0; duration = '0; periodic = 1'b0; cancel = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_fire", {63'd0, fire}, 64'd0);
    checkOutput("rst_late", {63'd0, fireLate}, 64'd0);
    checkOutput("rst_stamp", fireStamp, 64'd0);
    reset = 1'b0;

    // One-shot: start at 100, duration 5
    armTimer(64'd100, 64'd5, 1'b0);
    applyStimulus();
    checkOutput("os_busy", {63'd0, busy}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput("os_nofire", {63'd0, fire}, 64'd0);
    end
    applyStimulus();
    checkOutput("os_fire", {63'd0, fire}, 64'd1);
    checkOutput("os_counter", counter, 64'd106);
    checkOutput("os_stamp", fireStamp, 64'd105);
    checkOutput("os_late", {63'd0, fireLate}, 64'd0);
    checkOutput("os_busy_off", {63'd0, busy}, 64'd0);
    applyStimulus();
    checkOutput("os_pulse1", {63'd0, fire}, 64'd0);
    checkOutput("os_hold_stamp", fireStamp, 64'd105);

    // Periodic across wrap: deadlines 1, 5, 9
    armTimer(64'hFFFF_FFFF_FFFF_FFFD, 64'd4, 1'b1);
    applyStimulus();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        applyStimulus();
        checkOutput("per_nofire", {63'd0, fire}, 64'd0);
      end
      applyStimulus();
      checkOutput("per_fire", {63'd0, fire}, 64'd1);
      checkOutput("per_stamp", fireStamp, 64'd1 + 64'(4 * k));
      checkOutput("per_late", {63'd0, fireLate}, 64'd0);
      checkOutput("per_busy", {63'd0, busy}, 64'd1);
    end
    cancel = 1'b1;
    applyStimulus();
    checkOutput("per_cancel_busy", {63'd0, busy}, 64'd0);

    // Cancel in the match cycle
    armTimer(64'd200, 64'd3, 1'b0);
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("cx_counter", counter, 64'd203);
    cancel = 1'b1;
    applyStimulus();
    checkOutput("cx_nofire", {63'd0, fire}, 64'd0);
    checkOutput("cx_busy", {63'd0, busy}, 64'd0);
    repeat (3) begin
      applyStimulus();
      checkOutput("cx_later", {63'd0, fire}, 64'd0);
    end

    // Restart: duration 10 then duration 2 four cycles later
    armTimer(64'd300, 64'd10, 1'b0);
    repeat (4) applyStimulus();
    armTimer(64'd304, 64'd2, 1'b0);
    applyStimulus();
    checkOutput("rs_nofire0", {63'd0, fire}, 64'd0);
    applyStimulus();
    checkOutput("rs_nofire1", {63'd0, fire}, 64'd0);
    applyStimulus();
    checkOutput("rs_fire", {63'd0, fire}, 64'd1);
    checkOutput("rs_stamp", fireStamp, 64'd306);
    checkOutput("rs_busy", {63'd0, busy}, 64'd0);
    repeat (8) begin
      applyStimulus();
      checkOutput("rs_noold", {63'd0, fire}, 64'd0);
    end

    // Counter jump 5 -> 35 with period 10
    armTimer(64'd0, 64'd10, 1'b1);
    repeat (6) applyStimulus();
    checkOutput("cj_nofire", {63'd0, fire}, 64'd0);
    counter = 64'd35;
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      checkOutput("cj_fire", {63'd0, fire}, 64'd1);
      checkOutput("cj_stamp", fireStamp, 64'd35 + 64'(k));
      checkOutput("cj_late", {63'd0, fireLate}, 64'd1);
    end
    applyStimulus();
    checkOutput("cj_gap0", {63'd0, fire}, 64'd0);
    applyStimulus();
    checkOutput("cj_gap1", {63'd0, fire}, 64'd0);
    applyStimulus();
    checkOutput("cj_fire40", {63'd0, fire}, 64'd1);
    checkOutput("cj_stamp40", fireStamp, 64'd40);
    checkOutput("cj_late40", {63'd0, fireLate}, 64'd0);
    cancel = 1'b1;
    applyStimulus();

    // Reset while armed
    armTimer(64'd500, 64'd5, 1'b0);
    applyStimulus();
    applyStimulus();
    reset = 1'b1;
    applyStimulus();
    checkOutput("mr_busy", {63'd0, busy}, 64'd0);
    checkOutput("mr_fire", {63'd0, fire}, 64'd0);
    checkOutput("mr_late", {63'd0, fireLate}, 64'd0);
    checkOutput("mr_stamp", fireStamp, 64'd0);
    reset = 1'b0;
    repeat (8) begin
      applyStimulus();
      checkOutput("mr_nofire", {63'd0, fire}, 64'd0);
    end

    // Duration zero acts as one
    armTimer(64'd600, 64'd0, 1'b0);
    applyStimulus();
    checkOutput("d0_busy", {63'd0, busy}, 64'd1);
    checkOutput("d0_nofire", {63'd0, fire}, 64'd0);
    applyStimulus();
    checkOutput("d0_fire", {63'd0, fire}, 64'd1);
    checkOutput("d0_stamp", fireStamp, 64'd601);
    checkOutput("d0_late", {63'd0, fireLate}, 64'd0);

    // Periodic with duration one fires every cycle
    armTimer(64'd700, 64'd1, 1'b1);
    applyStimulus();
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      checkOutput("p1_fire", {63'd0, fire}, 64'd1);
      checkOutput("p1_stamp", fireStamp, 64'd701 + 64'(k));
    end
    cancel = 1'b1;
    applyStimulus();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/deadline_timer64.md
# deadline_timer64

Deadline/alarm timer that consumes the timestamp stream of a free-running counter. Software or a controlling FSM arms it with a duration; it latches an absolute deadline, watches the incoming counter value, and emits a one-cycle `fire` pulse plus the timestamp at which it fired. It supports one-shot and periodic modes and sits downstream of the system free-running counter, beside the blocks that schedule timeouts.

## Interface
- `DATA_WIDTH`, 64: width of the timestamp, duration and deadline arithmetic.
- `clk` in 1: single clock, the same clock as the counter source.
- `reset` in 1: synchronous, active-high; clears all state.
- `counter` in `DATA_WIDTH`: current timestamp from the free-running counter.
  - Normally +1 per cycle.
  - May jump to 0 when the counter is reset.
- `start` in 1: arm request; single-cycle qualifier for `duration` and `periodic`.
- `duration` in `DATA_WIDTH`: unsigned tick count to the deadline, also the period in periodic mode.
- `periodic` in 1: sampled with `start`. 1 = re-arm after each fire.
- `cancel` in 1: disarm immediately.
- `busy` out 1: 1 while armed.
- `fire` out 1: one-cycle pulse at deadline.
- `fire_late` out 1: valid with `fire`. 1 if the counter had already passed the deadline at detection.
- `fire_stamp` out `DATA_WIDTH`: value of `counter` at detection; updated only on `fire`.

## Operation
- States:
  - IDLE: `busy`=0.
  - ARMED: `busy`=1.
- Per-cycle priority: `reset` > `cancel` > `start` > match.
- `cancel` (any state): go to IDLE. No fire, even if a match occurs the same cycle. A simultaneous `start` is ignored.
- `start` (IDLE or ARMED): arming rules.
  - Latch `D = (duration==0) ? 1 : duration`.
  - Set `deadline <= counter + D`, mod 2^DATA_WIDTH.
  - Latch `periodic`, then go to ARMED.
  - A `start` while ARMED restarts the timer. Any match in that cycle is discarded, with no fire.
- Match, in ARMED only: `diff = counter - deadline` (DATA_WIDTH-bit modular subtraction). Match when `diff[DATA_WIDTH-1]==0`, i.e. the counter is at or past the deadline within half the range. Wrap-around of the counter past 2^DATA_WIDTH−1 is handled by this rule.
- On a match:
  - Register `fire`=1 for one cycle.
  - `fire_stamp <= counter`.
  - `fire_late <= (diff != 0)`.
  - One-shot: go to IDLE.
  - Periodic: `deadline <= deadline + D` (not `counter + D`, so there is no drift) and stay ARMED.
- Periodic catch-up: if the counter jumped forward past several periods, the block fires on consecutive cycles until the deadline is ahead of the counter again. Each of those fires has `fire_late`=1.
- Counter jumping backward (counter reset): `deadline` is not adjusted. The block fires when the counter reaches the deadline again or is within half-range of passing it.
- Arithmetic is unsigned modular throughout. The sign bit of `diff` is the only signed interpretation.

## Timing
- Reset values: state IDLE, `busy`=0, `fire`=0, `fire_late`=0, `fire_stamp`=0, internal `deadline`=0, `D`=0.
- `busy` rises in the cycle after `start` and falls in the cycle after a one-shot match or after `cancel`.
- Latency: `start` in cycle T with `counter`=C and duration D≥1.
  - Deadline is C+D; the counter equals C+D in cycle T+D.
  - `fire` is high in cycle T+D+1, with `fire_stamp`=C+D and `fire_late`=0.
- `fire` is never high for two consecutive cycles except during periodic catch-up or when D=1 periodic. With D=1 periodic it fires every cycle.
- `fire_stamp`/`fire_late` hold their values between fires.
- Reset mid-operation: the next cycle is in reset state. A pending fire is dropped. A `fire` already registered is cleared.

## Test plan
- One-shot: counter=100 at `start`, duration=5 → `fire` exactly one cycle when counter=106 is presented; `fire_stamp`=105, `fire_late`=0, `busy` low afterwards.
- Periodic with wrap: counter=2^64−3, duration=4, periodic=1 → fires with `fire_stamp`=1, 5, 9 (4-cycle spacing), `fire_late`=0 each time.
- Cancel vs match: arm with duration=3, assert `cancel` in the match cycle → no `fire`, `busy`=0 next cycle.
- Restart: arm duration=10, then `start` with duration=2 at +4 cycles → single fire 3 cycles after the second `start`; no fire at the original deadline.
- Counter jump: periodic duration=10 armed at 0; the counter jumps from 5 to 35 → three consecutive `fire` pulses, `fire_late`=1, `fire_stamp`=35, 36, 37, then normal spacing with next deadline 40.
- Reset mid-arm and duration=0: `reset` while ARMED → all outputs 0, no later fire; `start` with duration=0 → behaves as duration=1.
